hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
// Parametrised hazard and forwarding controller for the 5-stage (F/D/E/M/W) RV32I pipeline.
// - Generates stall, flush and forwarding selects for the pipeline registers and the E-stage operand muxes.
// - Adds a configurable load-use stall length (multi-cycle data memory), per-stage valid tracking and a post-reset flush.
// - Sits beside the four pipeline-register blocks and is driven by the D/E/M/W register-address and control fields.
// PARAMETERS
// REG_ADDR_WIDTH  5  register-index width; index 0 is hard-wired zero and is never forwarded or stalled on
// LOAD_LATENCY    1  total stall cycles for a load-use hazard, legal range 1..7
// CNT_WIDTH       3  width of the stall counter; must satisfy 2**CNT_WIDTH > LOAD_LATENCY
// PORTS
// clk        in   1               clock, rising edge
// rst        in   1               asynchronous active-low reset
// valid_f    in   1               fetch stage holds a real instruction
// rs1_d      in   REG_ADDR_WIDTH  source 1 of the instruction in D
// rs2_d      in   REG_ADDR_WIDTH  source 2 of the instruction in D
// rs1_e      in   REG_ADDR_WIDTH  source 1 of the instruction in E
// rs2_e      in   REG_ADDR_WIDTH  source 2 of the instruction in E
// rd_e       in   REG_ADDR_WIDTH  destination of the instruction in E
// rd_m       in   REG_ADDR_WIDTH  destination of the instruction in M
// rd_w       in   REG_ADDR_WIDTH  destination of the instruction in W
// reg_wr_e   in   1               E-stage instruction writes the register file
// reg_wr_m   in   1               M-stage instruction writes the register file
// reg_wr_w   in   1               W-stage instruction writes the register file
// load_e     in   1               E-stage instruction is a load (ResultSrcE)
// pc_src_e   in   1               branch taken or jump resolved in E
// stall_f    out  1               hold the PC
// stall_d    out  1               hold the F/D register
// flush_d    out  1               clear the F/D register to a bubble
// flush_e    out  1               clear the D/E register to a bubble
// fwd_a_e    out  2               ALU operand-1 select: 00 = RD1E, 01 = W result, 10 = M ALU result
// fwd_b_e    out  2               ALU operand-2 select: same encoding as fwd_a_e
// BEHAVIOUR
// Reset and startup
// - While rst is low: FSM = RUN, stall counter = 0, internal valids v_d/v_e/v_m/v_w = 0.
// - Outputs while rst is low: stall_f = stall_d = 0, flush_d = flush_e = 1, fwd_a_e = fwd_b_e = 00.
// - First clock after rst rises: flush_d and flush_e stay 1 for exactly one cycle (registered startup flag).
// Valid tracking, updated every rising edge
// - v_d <= flush_d ? 0 : (stall_d ? v_d : valid_f).
// - v_e <= flush_e ? 0 : v_d.
// - v_m <= v_e.
// - v_w <= v_m.
// Forwarding (combinational, operand A; operand B identical using rs2_e)
// - 10 if v_m & reg_wr_m & rd_m != 0 & rd_m == rs1_e.
// - else 01 if v_w & reg_wr_w & rd_w != 0 & rd_w == rs1_e.
// - else 00. M has priority over W.
// Load-use detection
// - lw_hz = v_e & load_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d).
// FSM states RUN and LDSTALL
// - RUN with lw_hz & !pc_src_e: assert stall_f, stall_d and flush_e this cycle.
//   - If LOAD_LATENCY > 1: load cnt <= LOAD_LATENCY-2 and go to LDSTALL.
//   - Otherwise stay in RUN.
// - LDSTALL: assert stall_f, stall_d and flush_e. If cnt == 0 go to RUN, else cnt <= cnt-1.
// - The load itself advances to M/W; the consumer issues on the cycle after the stall ends, receiving W-forwarded data.
// Control hazard
// - pc_src_e: flush_d = flush_e = 1, stall_f = stall_d = 0 that cycle.
// - Any stall is cancelled and the FSM returns to RUN; flush wins over stall.
// Boundary cases
// - Load with rd = x0: no stall.
// - Both sources match rd_e: single stall sequence.
// - Back-to-back dependent loads each stall independently.
// - rst asserted mid-LDSTALL: immediate return to the reset state.
// STRUCTURE
// - Shared package riscv_pipe_pkg:
//   - typedef fwd_sel_t (FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10);
//   - typedef hz_state_t (RUN, LDSTALL);
//   - REG_ZERO constant.
// - One sub-module fwd_sel (pure combinational), instantiated twice for operands A and B.
// - The FSM, counter, valid pipeline and startup flag stay in hazard_ctrl.
// TESTING
// 1. Reset, then release rst
//    -> flush_d = flush_e = 1 for one cycle, then 0.
//    -> Stalls 0 and fwd = 00 throughout.
// 2. add x5,x1,x2 then sub x6,x5,x3 back-to-back
//    -> fwd_a_e = 10 while sub is in E.
//    -> With one nop between them: fwd_a_e = 01.
// 3. Same as 2 with rd = x0
//    -> fwd_a_e = fwd_b_e = 00.
// 4. lw x7,0(x1) then add x8,x7,x7
//    -> LOAD_LATENCY = 1: stall_f = stall_d = flush_e = 1 for 1 cycle, then fwd_a_e = fwd_b_e = 01.
//    -> LOAD_LATENCY = 3: the same outputs for 3 cycles.
// 5. pc_src_e = 1 in the same cycle as lw_hz
//    -> flush_d = flush_e = 1, stall_f = stall_d = 0, FSM = RUN.
// 6. rst pulled low during cycle 2 of a 3-cycle stall
//    -> Stalls drop immediately, flushes assert.
//    -> No residual stall after release.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32I pipeline control blocks: forwarding selects,
// hazard-FSM states and the hard-wired zero register index.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } hz_state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// E-stage operand forwarding select for one ALU operand.
// The M stage wins over W because it holds the younger result.
module fwd_sel
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rsE,
    input  logic [REG_ADDR_WIDTH-1:0] rdM,
    input  logic [REG_ADDR_WIDTH-1:0] rdW,
    input  logic                      regWrM,
    input  logic                      regWrW,
    input  logic                      validM,
    input  logic                      validW,
    output logic [1:0]                sel
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(REG_ZERO);

    logic hitM;
    logic hitW;

    assign hitM = validM && regWrM && (rdM != ZERO_IDX) && (rdM == rsE);
    assign hitW = validW && regWrW && (rdW != ZERO_IDX) && (rdW == rsE);

    always_comb begin
        sel = FWD_RF;
        if (hitM) begin
            sel = FWD_M;
        end else if (hitW) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: load-use
// stall sequencing, control-hazard flushes, per-stage valids and startup flush.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   RUN     | normal issue; a load-use hazard stalls for the first cycle here
//   LDSTALL | remaining load-use stall cycles, counted down by cnt to 0
module hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LOAD_LATENCY   = 1,
    parameter int CNT_WIDTH      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_f,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_wr_e,
    input  logic                      reg_wr_m,
    input  logic                      reg_wr_w,
    input  logic                      load_e,
    input  logic                      pc_src_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e,
    output logic [1:0]                fwd_a_e,
    output logic [1:0]                fwd_b_e
);

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(REG_ZERO);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
        (LOAD_LATENCY > 1) ? CNT_WIDTH'(LOAD_LATENCY - 2) : '0;

    hz_state_t            state;
    hz_state_t            stateNext;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cntNext;
    logic                 startFlag;
    logic                 vD;
    logic                 vE;
    logic                 vM;
    logic                 vW;
    logic                 lwHz;
    logic                 stallReq;

    // A load always writes its rd, so load_e alone qualifies the hazard.
    logic unusedRegWrE;
    assign unusedRegWrE = reg_wr_e;

    assign lwHz = vE && load_e && (rd_e != ZERO_IDX)
                  && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        stallReq  = 1'b0;
        case (state)
            RUN: begin
                if (lwHz && !pc_src_e) begin
                    stallReq = 1'b1;
                    if (LOAD_LATENCY > 1) begin
                        stateNext = LDSTALL;
                        cntNext   = CNT_LOAD;
                    end
                end
            end
            LDSTALL: begin
                if (pc_src_e) begin
                    stateNext = RUN;
                end else begin
                    stallReq = 1'b1;
                    if (cnt == '0) begin
                        stateNext = RUN;
                    end else begin
                        cntNext = cnt - CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                stateNext = RUN;
                cntNext   = '0;
            end
        endcase
    end

    // A redirect (or the startup flag) flushes and overrides any stall request.
    assign stall_f = stallReq;
    assign stall_d = stallReq;
    assign flush_d = startFlag || pc_src_e;
    assign flush_e = startFlag || pc_src_e || stallReq;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            cnt       <= '0;
            startFlag <= 1'b1;
            vD        <= 1'b0;
            vE        <= 1'b0;
            vM        <= 1'b0;
            vW        <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            startFlag <= 1'b0;
            vD        <= flush_d ? 1'b0 : (stall_d ? vD : valid_f);
            vE        <= flush_e ? 1'b0 : vD;
            vM        <= vE;
            vW        <= vM;
        end
    end

    fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdA (
        .rsE    (rs1_e),
        .rdM    (rd_m),
        .rdW    (rd_w),
        .regWrM (reg_wr_m),
        .regWrW (reg_wr_w),
        .validM (vM),
        .validW (vW),
        .sel    (fwd_a_e)
    );

    fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) uFwdB (
        .rsE    (rs2_e),
        .rdM    (rd_m),
        .rdW    (rd_w),
        .regWrM (reg_wr_m),
        .regWrW (reg_wr_w),
        .validM (vM),
        .validW (vW),
        .sel    (fwd_b_e)
    );

endmodule
